alu_share_ctrl: RTL and testbench

Sequencing controller that time-shares the single 32-bit combinational ALU between two requesters, the main datapath (port 0) and the branch-compare path (port 1). Each request is accepted over a valid/ready handshake, arbitrated round-robin, registered into the ALU operand registers, and executed. The result and zero flag are then returned on that requester's response channel. The block sits between the decode/issue stage and the ALU instance it owns.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 27 ++
 rtl/alu_rr_arb.sv | 15 +
 rtl/alu_share_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: ALU control codes, FSM state type,
// default datapath width and the legal-opcode helper.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU_SLT is deliberately absent: the ALU treats it like any other unlisted code.
    function automatic logic ctrl_legal(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both requesters. Unlisted control codes pass operand a through.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = a;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = a;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant: on a tie the port that did not own the last operation wins.
module alu_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_owner ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between the datapath (port 0) and branch-compare path (port 1).
// Optional illegal-opcode reporting is enabled with macro ALU_SHARE_ERR_EN.
//
// state   | meaning
// IDLE    | waiting for a request; grant is combinational, operands latched on accept
// EXEC    | operand registers drive the ALU; result, zero and err are registered
// RESP    | resp<owner>_valid held with stable result until resp<owner>_ready
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    state_t            state;
    logic              last_owner;
    logic              owner;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        op_ctrl;
    logic [1:0]        grant;
    logic              accept_ok;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              op_err;
    logic [DATA_W-1:0] exec_result;
    logic              exec_zero;
    logic              resp_taken;

    alu_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_owner (last_owner),
        .grant      (grant)
    );

    alu #(.DATA_W(DATA_W)) u_alu (
        .ctrl   (op_ctrl),
        .a      (op_a),
        .b      (op_b),
        .result (alu_out),
        .zero   (alu_zero)
    );

    // Ready is masked during reset so no request is acknowledged and then discarded.
    assign accept_ok  = (state == ST_IDLE) && !reset;
    assign req0_ready = accept_ok && grant[0];
    assign req1_ready = accept_ok && grant[1];
    assign busy       = (state != ST_IDLE);
    assign resp_taken = owner ? resp1_ready : resp0_ready;

`ifdef ALU_SHARE_ERR_EN
    assign op_err      = !ctrl_legal(op_ctrl);
    assign exec_result = op_err ? '0 : alu_out;
    assign exec_zero   = op_err ? 1'b0 : alu_zero;
`else
    assign op_err      = 1'b0;
    assign exec_result = alu_out;
    assign exec_zero   = alu_zero;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_owner  <= 1'b1;
            owner       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_ctrl     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            ops_done    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner   <= grant[1];
                        op_a    <= grant[1] ? req1_a    : req0_a;
                        op_b    <= grant[1] ? req1_b    : req0_b;
                        op_ctrl <= grant[1] ? req1_ctrl : req0_ctrl;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result <= exec_result;
                    resp_zero   <= exec_zero;
                    resp_err    <= op_err;
                    resp0_valid <= !owner;
                    resp1_valid <= owner;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_taken) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        ops_done    <= ops_done + CNT_W'(1);
                        last_owner  <= owner;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the shared-ALU behaviour.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_ctrl = '0, req1_ctrl = '0;
    logic          resp0_valid, resp1_valid;
    logic          resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [DW-1:0] resp_result;
    logic          resp_zero, resp_err, busy;
    logic [CW-1:0] ops_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .busy(busy), .ops_done(ops_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation table; illegal codes depend on the error feature.
    function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic z, output logic e);
        e = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            default: begin
                r = a;
`ifdef ALU_SHARE_ERR_EN
                e = 1'b1;
                r = 32'd0;
`endif
            end
        endcase
        z = (r == 32'd0) && !e;
    endfunction

    // Transaction model: one op in flight, its age in cycles since acceptance decides visibility.
    logic        m_on = 1'b0;
    logic        m_inflight = 1'b0;
    int          m_age = 0;
    int          m_owner = 0;
    logic        m_last = 1'b1;
    int          m_count = 0;
    logic [31:0] m_pend_res, m_show_res = '0;
    logic        m_pend_zero, m_show_zero = 1'b0;
    logic        m_pend_err, m_show_err = 1'b0;
    int          m_g;
    logic        m_rv0, m_rv1;

    always @(negedge clk) begin
        m_g = -1;
        if (!m_inflight && !reset) begin
            if (req0_valid && req1_valid) m_g = m_last ? 0 : 1;
            else if (req0_valid)          m_g = 0;
            else if (req1_valid)          m_g = 1;
        end
        m_rv0 = m_inflight && (m_age >= 2) && (m_owner == 0);
        m_rv1 = m_inflight && (m_age >= 2) && (m_owner == 1);
        if (m_on) begin
            check("req0_ready", 32'(req0_ready), 32'(m_g == 0));
            check("req1_ready", 32'(req1_ready), 32'(m_g == 1));
            check("resp0_valid", 32'(resp0_valid), 32'(m_rv0));
            check("resp1_valid", 32'(resp1_valid), 32'(m_rv1));
            check("busy", 32'(busy), 32'(m_inflight));
            check("ops_done", 32'(ops_done), 32'(m_count % 16));
            check("resp_result", resp_result, m_show_res);
            check("resp_zero", 32'(resp_zero), 32'(m_show_zero));
            check("resp_err", 32'(resp_err), 32'(m_show_err));
        end
        if (reset) begin
            m_on = 1'b1; m_inflight = 1'b0; m_count = 0; m_last = 1'b1;
            m_show_res = '0; m_show_zero = 1'b0; m_show_err = 1'b0;
        end else if (m_on) begin
            if (!m_inflight) begin
                if (m_g >= 0) begin
                    m_inflight = 1'b1;
                    m_age = 1;
                    m_owner = m_g;
                    if (m_g == 0) ref_op(req0_ctrl, req0_a, req0_b, m_pend_res, m_pend_zero, m_pend_err);
                    else          ref_op(req1_ctrl, req1_a, req1_b, m_pend_res, m_pend_zero, m_pend_err);
                end
            end else if (m_age == 1) begin
                m_age = 2;
                m_show_res = m_pend_res; m_show_zero = m_pend_zero; m_show_err = m_pend_err;
            end else if ((m_owner == 0) ? resp0_ready : resp1_ready) begin
                m_inflight = 1'b0;
                m_count = m_count + 1;
                m_last = (m_owner == 1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ready) begin g = 0; break; end
            if (req1_ready) begin g = 1; break; end
        end
        if (g < 0) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got none expected a grant");
        end
        cyc();
    endtask

    // Returns at the negedge where the requested response is visible.
    task automatic wait_resp(input int p);
        logic seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((p == 0) ? resp0_valid : resp1_valid) begin seen = 1'b1; break; end
            cyc();
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL resp_timeout: port %0d got none expected valid", p);
        end
    endtask

    function automatic logic [3:0] rand_ctrl();
        logic [3:0] tbl [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'hF, 4'h2};
        return tbl[$urandom_range(0, 7)];
    endfunction

    initial begin
        int g;
        int done;
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", resp_result, 32'd0);
        cyc();

        // single add on port 0
        req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0010; req0_valid = 1'b1; resp0_ready = 1'b1;
        wait_grant(g);
        check("single_grant", 32'(g), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", 32'(resp0_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("lat_t2_valid", 32'(resp0_valid), 32'd1);
        check("add_result", resp_result, 32'd8);
        check("add_zero", 32'(resp_zero), 32'd0);
        cyc();
        @(negedge clk);
        check("single_ops_done", 32'(ops_done), 32'd1);
        cyc();

        // round-robin after reset
        do_reset();
        req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = 4'b0110;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 4'b0001;
        req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
        wait_grant(g);
        check("rr_first", 32'(g), 32'd0);
        wait_resp(0);
        check("sub_result", resp_result, 32'd0);
        check("sub_zero", 32'(resp_zero), 32'd1);
        cyc();
        wait_grant(g);
        check("rr_second", 32'(g), 32'd1);
        wait_resp(1);
        check("or_result", resp_result, 32'hFF);
        cyc();
        wait_grant(g);
        check("rr_third", 32'(g), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(0);
        cyc();

        // backpressure on port 1
        req1_a = 32'd1; req1_b = 32'd2; req1_ctrl = 4'b0010; req1_valid = 1'b1; resp1_ready = 1'b0;
        wait_grant(g);
        check("bp_grant", 32'(g), 32'd1);
        req1_valid = 1'b0; req0_valid = 1'b1;
        wait_resp(1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            check("bp_valid", 32'(resp1_valid), 32'd1);
            check("bp_result", resp_result, 32'd3);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        cyc();
        resp1_ready = 1'b1;
        cyc();
        wait_grant(g);
        check("bp_after_grant", 32'(g), 32'd0);
        req0_valid = 1'b0;
        wait_resp(0);
        cyc();

        // reset while in EXEC
        req0_a = 32'd9; req0_b = 32'd2; req0_ctrl = 4'b0010; req0_valid = 1'b1;
        wait_grant(g);
        reset = 1'b1; req0_valid = 1'b0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstx_resp0_valid", 32'(resp0_valid), 32'd0);
            check("rstx_busy", 32'(busy), 32'd0);
            check("rstx_ops_done", 32'(ops_done), 32'd0);
            check("rstx_result", resp_result, 32'd0);
            cyc();
        end

        // code 0111 on port 1
        req1_a = 32'd9; req1_b = 32'd2; req1_ctrl = 4'b0111; req1_valid = 1'b1; resp1_ready = 1'b1;
        wait_grant(g);
        req1_valid = 1'b0;
        wait_resp(1);
`ifdef ALU_SHARE_ERR_EN
        check("illegal_err", 32'(resp_err), 32'd1);
        check("illegal_result", resp_result, 32'd0);
`else
        check("illegal_err", 32'(resp_err), 32'd0);
        check("illegal_result", resp_result, 32'd9);
`endif
        cyc();

        // 17 back-to-back ops wrap the 4-bit counter to 1
        do_reset();
        req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b0010; req0_valid = 1'b1; resp0_ready = 1'b1;
        done = 0;
        for (int i = 0; i < 200 && done < 17; i++) begin
            @(negedge clk);
            if (resp0_valid && resp0_ready) done++;
            cyc();
        end
        req0_valid = 1'b0;
        @(negedge clk);
        check("wrap_count", 32'(done), 32'd17);
        check("wrap_ops_done", 32'(ops_done), 32'd1);
        cyc();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            req0_valid  = ($urandom_range(0, 99) < 60);
            req1_valid  = ($urandom_range(0, 99) < 60);
            req0_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req0_b      = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_b      = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            req0_ctrl   = rand_ctrl();
            req1_ctrl   = rand_ctrl();
            resp0_ready = ($urandom_range(0, 99) < 70);
            resp1_ready = ($urandom_range(0, 99) < 70);
            cyc();
        end
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
